// File: rtl/seg_scan_ctrl_pkg.sv
// Shared definitions for the 7-segment scan controller.
//   scan_state_e : BLANK / DRIVE scan phases
//   digit_t      : one register-file entry {dp, hex}
//   seg_drv()    : hex nibble -> {g,f,e,d,c,b,a}, active-high
//   SEG_OFF      : all segments dark (active-low bus)
package seg_scan_ctrl_pkg;

  localparam logic [7:0] SEG_OFF = 8'hFF;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } scan_state_e;

  typedef struct packed {
    logic       dp;
    logic [3:0] hex;
  } digit_t;

  // Standard hex font, segment a in bit 0.
  function automatic logic [6:0] seg_drv(input logic [3:0] hex);
    logic [6:0] s;
    case (hex)
      4'h0:    s = 7'h3F;
      4'h1:    s = 7'h06;
      4'h2:    s = 7'h5B;
      4'h3:    s = 7'h4F;
      4'h4:    s = 7'h66;
      4'h5:    s = 7'h6D;
      4'h6:    s = 7'h7D;
      4'h7:    s = 7'h07;
      4'h8:    s = 7'h7F;
      4'h9:    s = 7'h6F;
      4'hA:    s = 7'h77;
      4'hB:    s = 7'h7C;
      4'hC:    s = 7'h39;
      4'hD:    s = 7'h5E;
      4'hE:    s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg_digit_file.sv
// NUM_SEG x {dp,hex} digit register file.
//   clk, rst            : clock, synchronous active-high reset (file cleared)
//   sh_en, sh_data      : shift-in commit (digit i -> i+1, new hex into digit 0, dp cleared)
//   wr_en, wr_idx,      : write commit, applied after any same-cycle shift;
//   wr_digit              indices >= NUM_SEG are ignored
//   rd_idx, rd_digit_c  : combinational read of the post-commit contents
module seg_digit_file
  import seg_scan_ctrl_pkg::*;
#(
  parameter int unsigned NUM_SEG = 6,
  parameter int unsigned IDXW    = $clog2(NUM_SEG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            sh_en,
  input  logic [3:0]      sh_data,
  input  logic            wr_en,
  input  logic [IDXW-1:0] wr_idx,
  input  digit_t          wr_digit,
  input  logic [IDXW-1:0] rd_idx,
  output digit_t          rd_digit_c
);

  digit_t file_q [NUM_SEG];
  digit_t file_d [NUM_SEG];

  // Shift first, then write into the shifted image.
  always_comb begin
    file_d = file_q;
    if (sh_en) begin
      for (int unsigned i = 1; i < NUM_SEG; i++) file_d[i] = file_q[i-1];
      file_d[0] = '{dp: 1'b0, hex: sh_data};
    end
    for (int unsigned i = 0; i < NUM_SEG; i++) begin
      if (wr_en && (wr_idx == IDXW'(i))) file_d[i] = wr_digit;
    end
  end

  // Read the next-state image so a commit on the BLANK->DRIVE edge is shown at once.
  always_comb begin
    rd_digit_c = '0;
    for (int unsigned i = 0; i < NUM_SEG; i++) begin
      if (rd_idx == IDXW'(i)) rd_digit_c = file_d[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) file_q <= '{default: '0};
    else     file_q <= file_d;
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode 7-segment bank.
//   clk, rst             : clock, synchronous active-high reset
//   en                   : 1 = scan, 0 = force blank and freeze scan position
//   wr_valid/ready/idx/  : digit write over valid/ready, held in a 1-entry slot
//   data/dp                and committed during a blank slot
//   sh_valid/ready/data  : shift-in request, same slot scheme, independent
//   seg_n                : {dp,g,f,e,d,c,b,a}, active-low
//   dig_n                : digit enables, active-low, one-cold while driving
//   frame_tick           : 1-cycle pulse when the scan wraps to digit 0
// IDXW may be widened beyond $clog2(NUM_SEG); out-of-range writes are dropped.
module seg_scan_ctrl
  import seg_scan_ctrl_pkg::*;
#(
  parameter int unsigned NUM_SEG   = 6,
  parameter int unsigned DWELL_CYC = 1000,
  parameter int unsigned BLANK_CYC = 16,
  parameter int unsigned IDXW      = $clog2(NUM_SEG)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [IDXW-1:0]    wr_idx,
  input  logic [3:0]         wr_data,
  input  logic               wr_dp,
  input  logic               sh_valid,
  output logic               sh_ready,
  input  logic [3:0]         sh_data,
  output logic [7:0]         seg_n,
  output logic [NUM_SEG-1:0] dig_n,
  output logic               frame_tick
);

  localparam int unsigned     CNT_MAX    = (DWELL_CYC > BLANK_CYC) ? DWELL_CYC : BLANK_CYC;
  localparam int unsigned     CNTW       = $clog2(CNT_MAX + 1);
  localparam logic [CNTW-1:0] BLANK_LAST = CNTW'(BLANK_CYC - 1);
  localparam logic [CNTW-1:0] DWELL_LAST = CNTW'(DWELL_CYC - 1);
  localparam logic [IDXW-1:0] PTR_LAST   = IDXW'(NUM_SEG - 1);

  scan_state_e          state_q, state_d;
  logic [CNTW-1:0]      cnt_q, cnt_d;
  logic [IDXW-1:0]      ptr_q, ptr_d;
  logic                 paused_q, paused_d;
  logic                 tick_d;
  logic [7:0]           seg_d;
  logic [NUM_SEG-1:0]   dig_d;
  digit_t               rd_digit_c;

  logic [IDXW-1:0]      wr_idx_q;
  digit_t               wr_digit_q;
  logic [3:0]           sh_data_q;
  logic                 wr_commit_c, sh_commit_c;

  // Slots drain only while every digit is dark.
  assign wr_commit_c = !wr_ready && (state_q == ST_BLANK);
  assign sh_commit_c = !sh_ready && (state_q == ST_BLANK);

  seg_digit_file #(
    .NUM_SEG (NUM_SEG),
    .IDXW    (IDXW)
  ) u_file (
    .clk        (clk),
    .rst        (rst),
    .sh_en      (sh_commit_c),
    .sh_data    (sh_data_q),
    .wr_en      (wr_commit_c),
    .wr_idx     (wr_idx_q),
    .wr_digit   (wr_digit_q),
    .rd_idx     (ptr_d),
    .rd_digit_c (rd_digit_c)
  );

  // Scan FSM next state and next registered outputs.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ptr_d    = ptr_q;
    paused_d = paused_q;
    tick_d   = 1'b0;
    seg_d    = SEG_OFF;
    dig_d    = '1;

    if (!en) begin
      // Park in BLANK; cnt/ptr held, restart handled on re-enable.
      state_d  = ST_BLANK;
      paused_d = 1'b1;
    end else if (paused_q) begin
      state_d  = ST_BLANK;
      cnt_d    = '0;
      paused_d = 1'b0;
    end else begin
      case (state_q)
        ST_BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            state_d = ST_DRIVE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNTW'(1);
          end
        end
        ST_DRIVE: begin
          if (cnt_q == DWELL_LAST) begin
            state_d = ST_BLANK;
            cnt_d   = '0;
            ptr_d   = (ptr_q == PTR_LAST) ? '0 : ptr_q + IDXW'(1);
            tick_d  = (ptr_q == PTR_LAST);
          end else begin
            cnt_d = cnt_q + CNTW'(1);
          end
        end
        default: state_d = ST_BLANK;
      endcase
    end

    if (state_d == ST_DRIVE) begin
      dig_d = ~(NUM_SEG'(1) << ptr_d);
      seg_d = {~rd_digit_c.dp, ~seg_drv(rd_digit_c.hex)};
    end
  end

  // Scan state and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_BLANK;
      cnt_q      <= '0;
      ptr_q      <= '0;
      paused_q   <= 1'b0;
      seg_n      <= SEG_OFF;
      dig_n      <= '1;
      frame_tick <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ptr_q      <= ptr_d;
      paused_q   <= paused_d;
      seg_n      <= seg_d;
      dig_n      <= dig_d;
      frame_tick <= tick_d;
    end
  end

  // Write and shift holding slots; ready is the slot-empty flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ready   <= 1'b1;
      sh_ready   <= 1'b1;
      wr_idx_q   <= '0;
      wr_digit_q <= '0;
      sh_data_q  <= '0;
    end else begin
      if (wr_valid && wr_ready) begin
        wr_ready   <= 1'b0;
        wr_idx_q   <= wr_idx;
        wr_digit_q <= '{dp: wr_dp, hex: wr_data};
      end else if (wr_commit_c) begin
        wr_ready <= 1'b1;
      end
      if (sh_valid && sh_ready) begin
        sh_ready  <= 1'b0;
        sh_data_q <= sh_data;
      end else if (sh_commit_c) begin
        sh_ready <= 1'b1;
      end
    end
  end

endmodule
